raminfr: RTL and testbench
==========================

RAMINFR -- requirements
Module: raminfr

Interface
REQ-001 Parameter ADDR_W, default 5, address width of both ports.
REQ-002 Parameter DATA_W, default 4, data width of both ports.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), number of words.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising-edge active for both ports.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wea  input  1  port A write enable.
REQ-008 addra  input  ADDR_W  port A address.
REQ-009 dia  input  DATA_W  port A write data.
REQ-010 doa  output  DATA_W  port A registered read data.
REQ-011 web  input  1  port B write enable.
REQ-012 addrb  input  ADDR_W  port B address.
REQ-013 dib  input  DATA_W  port B write data.
REQ-014 dob  output  DATA_W  port B registered read data.

Function
REQ-015 Storage SHALL be DEPTH words of DATA_W bits, both ports accessing the full array.
REQ-016 Each port SHALL be independent: a write or read on every rising clk edge, with no handshake.
REQ-017 Port write: when we* is 1 at a clk edge, mem[addr*] SHALL take di* at that edge.
REQ-018 Read latency SHALL be 1 cycle: do* SHALL update at every clk edge, whether or not the port writes.
REQ-019 Same-port read-during-write SHALL be write-first: do* SHALL show the new di* after the edge.
REQ-020 Same-port read without a write SHALL give the value held in mem[addr*] before the edge.
REQ-021 Cross-port read: if one port writes an address that the other port reads in the same cycle, the reading port SHALL return the old data (read-first across ports).
REQ-022 Write collision (wea=web=1, addra==addrb): port A SHALL win, and mem SHALL take dia.
REQ-023 Write collision outputs: doa SHALL show dia, and dob SHALL show the old content.
REQ-024 Addresses SHALL be fully decoded with no wrap logic, because DEPTH equals 2**ADDR_W.

Reset
REQ-025 While rst_n is 0, doa, dob and every memory word SHALL be 0, asynchronously, without waiting for clk.
REQ-026 Writes SHALL be ignored while rst_n is 0.
REQ-027 The first active edge after rst_n rises SHALL operate normally.
REQ-028 Reset during a write SHALL discard that write.

Structure
REQ-029 Package raminfr_pkg SHALL hold the default ADDR_W, DATA_W and DEPTH constants and the data and address typedefs.
REQ-030 The design SHALL be a single module with no sub-module.
REQ-031 Port A and port B logic SHALL be symmetric processes, except for the collision priority in REQ-022.

Verification
REQ-032 Directed scenario, reset: rst_n=0 -> doa=0 and dob=0 at once, and every address reads 0 after release.
REQ-033 Directed scenario, parallel writes: wea=web=1, addra=6, dia=0xA, addrb=7, dib=0xB, one edge -> doa=0xA, dob=0xB.
- Then we*=0, addra=7, addrb=6, one edge -> doa=0xB, dob=0xA.
REQ-034 Directed scenario, cross-port read: mem[3]=0x2, then wea=1, addra=3, dia=0x5, web=0, addrb=3 -> dob=0x2 after that edge.
- The next edge -> dob=0x5.
REQ-035 Directed scenario, collision: wea=web=1, addra=addrb=9, dia=0x4, dib=0xC -> doa=0x4, then a read of address 9 -> 0x4.
REQ-036 Directed scenario, reset mid-operation: rst_n pulled low between edges while writing 0xF to address 31.
- Required response: outputs go to 0 immediately, and address 31 reads 0 after release.
REQ-037 Directed scenario, address sweep: write data = address[3:0] to all 32 words via port A, read them back via port B.
- Every word SHALL match.
- Port B SHALL have exactly 1-cycle latency.

Source files
------------

// File: rtl/raminfr_pkg.sv
// Shared defaults and typedefs for the dual-port inferred RAM.
package raminfr_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 4;
  localparam int unsigned RAM_DEPTH  = 32;

  typedef logic [RAM_ADDR_W-1:0] addr_t;
  typedef logic [RAM_DATA_W-1:0] data_t;

endpackage : raminfr_pkg

// File: rtl/raminfr.sv
// True dual-port RAM with registered outputs, resettable contents and port-A
// priority on same-address write collisions.
module raminfr
  import raminfr_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] doa_q, doa_d;
  logic [DATA_W-1:0] dob_q, dob_d;
  logic              wr_b_c;

  // Next read data: own write wins on the port, the other port sees old data.
  always_comb begin
    wr_b_c = 1'b0;
    doa_d  = '0;
    dob_d  = '0;
    wr_b_c = web && !(wea && (addra == addrb));
    doa_d  = wea    ? dia : mem_q[addra];
    dob_d  = wr_b_c ? dib : mem_q[addrb];
  end

  // Storage: cleared by reset; port B write suppressed when it collides with A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_b_c) begin
        mem_q[addrb] <= dib;
      end
      if (wea) begin
        mem_q[addra] <= dia;
      end
    end
  end

  // Port A registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doa_q <= '0;
    end else begin
      doa_q <= doa_d;
    end
  end

  // Port B registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dob_q <= '0;
    end else begin
      dob_q <= dob_d;
    end
  end

  assign doa = doa_q;
  assign dob = dob_q;

endmodule : raminfr

// File: tb/tb_raminfr.sv
// Self-checking bench for raminfr: reference model plus directed scenarios.
module tb_raminfr;
  import raminfr_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  wea, web;
  addr_t addra, addrb;
  data_t dia, dib;
  data_t doa, dob;

  int checks;
  int failures;

  raminfr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wea   (wea),
    .addra (addra),
    .dia   (dia),
    .doa   (doa),
    .web   (web),
    .addrb (addrb),
    .dib   (dib),
    .dob   (dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array of words plus expected outputs.
  data_t m_mem [32];
  data_t m_old [32];
  data_t m_doa, m_dob;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_doa = '0;
      m_dob = '0;
    end else begin
      for (int i = 0; i < 32; i++) m_old[i] = m_mem[i];
      // Each port reads the pre-edge contents, except its own effective write.
      m_doa = wea ? dia : m_old[addra];
      if (web && !(wea && addra == addrb)) m_dob = dib;
      else                                 m_dob = m_old[addrb];
      // Apply B then A so that A prevails on a shared address.
      if (web) m_mem[addrb] = dib;
      if (wea) m_mem[addra] = dia;
    end
  end

  task automatic chk(input string name, input data_t got, input data_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    chk("doa_model", doa, m_doa);
    chk("dob_model", dob, m_dob);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b1;
    wea = 1'b0; web = 1'b0;
    addra = '0; addrb = '0;
    dia = '0; dib = '0;

    // Reset: outputs clear immediately, then every word reads zero.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_doa", doa, 4'h0);
    chk("rst_async_dob", dob, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      addra = 5'(i);
      addrb = 5'(31 - i);
      step();
      chk("rst_read_a", doa, 4'h0);
      chk("rst_read_b", dob, 4'h0);
    end

    // Parallel writes to distinct addresses, then cross read-back.
    wea = 1'b1; addra = 5'd6; dia = 4'hA;
    web = 1'b1; addrb = 5'd7; dib = 4'hB;
    step();
    chk("par_wr_doa", doa, 4'hA);
    chk("par_wr_dob", dob, 4'hB);
    wea = 1'b0; web = 1'b0; addra = 5'd7; addrb = 5'd6;
    step();
    chk("par_rd_doa", doa, 4'hB);
    chk("par_rd_dob", dob, 4'hA);

    // Cross-port read during write returns old data first.
    wea = 1'b1; addra = 5'd3; dia = 4'h2; addrb = 5'd0;
    step();
    dia = 4'h5; addrb = 5'd3;
    step();
    chk("xrd_doa_new", doa, 4'h5);
    chk("xrd_dob_old", dob, 4'h2);
    wea = 1'b0;
    step();
    chk("xrd_dob_next", dob, 4'h5);

    // Write collision: port A wins, port B sees the old contents.
    wea = 1'b1; web = 1'b1; addra = 5'd9; addrb = 5'd9; dia = 4'h4; dib = 4'hC;
    step();
    chk("col_doa", doa, 4'h4);
    chk("col_dob_old", dob, 4'h0);
    wea = 1'b0; web = 1'b0;
    step();
    chk("col_rd_a", doa, 4'h4);
    chk("col_rd_b", dob, 4'h4);

    // Reset asserted between edges while a write is pending.
    wea = 1'b1; addra = 5'd31; dia = 4'hF; addrb = 5'd6;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_doa", doa, 4'h0);
    chk("midrst_dob", dob, 4'h0);
    step();
    rst_n = 1'b1;
    wea = 1'b0; addra = 5'd31; addrb = 5'd9;
    step();
    chk("midrst_rd31", doa, 4'h0);
    chk("midrst_rd9", dob, 4'h0);

    // Sweep: fill via port A, read back via port B with one-cycle latency.
    for (int i = 0; i < 32; i++) begin
      wea = 1'b1; addra = 5'(i); dia = 4'(i); addrb = 5'd0;
      step();
      chk("sweep_wr_first", doa, 4'(i));
    end
    wea = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addrb = 5'(i);
      #2;
      chk("sweep_pre_edge", dob, (i == 0) ? 4'h0 : 4'(i - 1));
      step();
      chk("sweep_rd", dob, 4'(i));
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_raminfr
